mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: merges instruction fetch, core LSU and
// coprocessor LSU requests onto one in-order memory port and routes the
// responses back using a tag FIFO that remembers source and word lane.
module mem_port_arbiter #(
  parameter int unsigned MEM_W      = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,

  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic [31:0]          data_addr_i,
  input  logic                 data_we_i,
  input  logic [MEM_W/8-1:0]   data_be_i,
  input  logic [MEM_W-1:0]     data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [MEM_W-1:0]     data_rdata_o,
  output logic                 data_err_o,

  input  logic                 xif_req_i,
  output logic                 xif_gnt_o,
  input  logic [31:0]          xif_addr_i,
  input  logic                 xif_we_i,
  input  logic [31:0]          xif_wdata_i,
  output logic                 xif_rvalid_o,
  output logic [31:0]          xif_rdata_o,
  output logic                 xif_err_o,

  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_we_o,
  output logic [MEM_W/8-1:0]   mem_be_o,
  output logic [MEM_W-1:0]     mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [MEM_W-1:0]     mem_rdata_i,
  input  logic                 mem_err_i,

  output logic                 busy_o,
  output logic                 proto_err_o
);

  localparam int unsigned BE_W   = MEM_W / 8;
  localparam int unsigned LANES  = MEM_W / 32;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_INSTR,
    SRC_DATA,
    SRC_XIF
  } src_e;

  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  src_e              tag_src_q  [DEPTH];
  logic [LANE_W-1:0] tag_lane_q [DEPTH];
  logic [STV_W-1:0]  starve_q;
  logic              rr_last_xif_q;
  logic              proto_err_q;

  src_e              sel;
  src_e              head_src;
  logic [LANE_W-1:0] head_lane;
  logic [LANE_W-1:0] sel_lane;
  logic [LANE_W-1:0] xif_lane;
  logic [31:0]       lane_rdata;
  logic              starved;
  logic              room;
  logic              accept;
  logic              pop;

  // Word lane within the memory bus addressed by a byte address; always 0 on a 32-bit bus.
  function automatic logic [LANE_W-1:0] addr_lane(input logic [31:0] addr);
    logic [31:0] word_idx;
    word_idx = (addr >> 2) & 32'(LANES - 1);
    return word_idx[LANE_W-1:0];
  endfunction

  assign starved  = (starve_q == STV_W'(STARVE_MAX));
  assign room     = (count_q < CNT_W'(DEPTH));
  assign xif_lane = addr_lane(xif_addr_i);

  // Requester selection: starved fetch first, then data/xif round-robin, then fetch.
  always_comb begin
    sel = SRC_NONE;
    if (instr_req_i && starved) begin
      sel = SRC_INSTR;
    end else if (data_req_i && xif_req_i) begin
      sel = rr_last_xif_q ? SRC_DATA : SRC_XIF;
    end else if (data_req_i) begin
      sel = SRC_DATA;
    end else if (xif_req_i) begin
      sel = SRC_XIF;
    end else if (instr_req_i) begin
      sel = SRC_INSTR;
    end
  end

  // Request is held low in reset so nothing can be accepted before the state is valid.
  assign mem_req_o   = (instr_req_i | data_req_i | xif_req_i) & room & rst_ni;
  assign accept      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = accept && (sel == SRC_INSTR);
  assign data_gnt_o  = accept && (sel == SRC_DATA);
  assign xif_gnt_o   = accept && (sel == SRC_XIF);

  // Request mux: fetches are full-width reads, xif words are replicated and byte-enabled in their lane.
  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_wdata_o = '0;
    case (sel)
      SRC_DATA: begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
      SRC_XIF: begin
        mem_addr_o  = xif_addr_i;
        mem_we_o    = xif_we_i;
        mem_be_o    = BE_W'(4'hF) << {xif_lane, 2'b00};
        mem_wdata_o = {LANES{xif_wdata_i}};
      end
      default: begin
      end
    endcase
  end

  assign sel_lane = addr_lane(mem_addr_o);

  // Responses come back in order, so the FIFO head always names the owner.
  assign pop       = mem_rvalid_i && (count_q != '0);
  assign head_src  = tag_src_q[rd_ptr_q];
  assign head_lane = tag_lane_q[rd_ptr_q];

  // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!accept && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Tag payload needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_src_q[wr_ptr_q]  <= sel;
      tag_lane_q[wr_ptr_q] <= sel_lane;
    end
  end

  // Starvation counter: counts denied fetch cycles and saturates at the override threshold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!instr_req_i || (accept && (sel == SRC_INSTR))) begin
      starve_q <= '0;
    end else if (!starved) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Round-robin pointer remembers whether xif won the last data/xif grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_xif_q <= 1'b1;
    end else if (accept && (sel == SRC_DATA)) begin
      rr_last_xif_q <= 1'b0;
    end else if (accept && (sel == SRC_XIF)) begin
      rr_last_xif_q <= 1'b1;
    end
  end

  // A response with nothing outstanding is a protocol violation, latched until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (mem_rvalid_i && (count_q == '0)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign lane_rdata     = 32'(mem_rdata_i >> {head_lane, 5'b00000});

  assign instr_rvalid_o = pop && (head_src == SRC_INSTR);
  assign data_rvalid_o  = pop && (head_src == SRC_DATA);
  assign xif_rvalid_o   = pop && (head_src == SRC_XIF);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign xif_err_o      = xif_rvalid_o & mem_err_i;
  assign instr_rdata_o  = lane_rdata;
  assign xif_rdata_o    = lane_rdata;
  assign data_rdata_o   = mem_rdata_i;

  assign busy_o         = (count_q != '0);
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single-cycle mux
// vectors, directed multi-cycle sequences and a randomized run, all compared
// against a queue-based reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MEM_W      = 64;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 15;
  localparam int BE_W       = MEM_W / 8;
  localparam int LANES      = MEM_W / 32;

  localparam int SEL_NONE = 0;
  localparam int SEL_I    = 1;
  localparam int SEL_D    = 2;
  localparam int SEL_X    = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]       instr_addr_i, instr_rdata_o;
  logic              data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [31:0]       data_addr_i;
  logic [BE_W-1:0]   data_be_i;
  logic [MEM_W-1:0]  data_wdata_i, data_rdata_o;
  logic              xif_req_i, xif_gnt_o, xif_we_i, xif_rvalid_o, xif_err_o;
  logic [31:0]       xif_addr_i, xif_wdata_i, xif_rdata_o;
  logic              mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [31:0]       mem_addr_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [MEM_W-1:0]  mem_wdata_o, mem_rdata_i;
  logic              busy_o, proto_err_o;

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MEM_W(MEM_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .xif_req_i(xif_req_i), .xif_gnt_o(xif_gnt_o), .xif_addr_i(xif_addr_i),
    .xif_we_i(xif_we_i), .xif_wdata_i(xif_wdata_i),
    .xif_rvalid_o(xif_rvalid_o), .xif_rdata_o(xif_rdata_o), .xif_err_o(xif_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int src;
    int lane;
  } tag_t;

  tag_t m_q[$];
  int   m_starve;
  bit   m_last_xif;
  bit   m_proto;
  int   p_sel;
  bit   p_req, p_acc, p_pop;

  logic             cap_instr_gnt, cap_data_gnt, cap_xif_gnt, cap_mem_req, cap_busy, cap_proto;
  logic             cap_instr_rvalid, cap_data_rvalid, cap_xif_rvalid, cap_mem_we;
  logic [31:0]      cap_instr_rdata, cap_xif_rdata, cap_mem_addr;
  logic [BE_W-1:0]  cap_mem_be;
  logic [MEM_W-1:0] cap_mem_wdata;

  typedef struct {
    logic             ir;
    logic             dr;
    logic             xr;
    logic [31:0]      xa;
    logic             e_req;
    logic [31:0]      e_addr;
    logic             e_we;
    logic [BE_W-1:0]  e_be;
    logic [MEM_W-1:0] e_wd;
    logic             chk_wd;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_of(input logic [31:0] a);
    return int'(a[31:2]) % LANES;
  endfunction

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    xif_req_i = 1'b0; xif_addr_i = '0; xif_we_i = 1'b0; xif_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic capture();
    cap_instr_gnt = instr_gnt_o; cap_data_gnt = data_gnt_o; cap_xif_gnt = xif_gnt_o;
    cap_mem_req = mem_req_o; cap_busy = busy_o; cap_proto = proto_err_o;
    cap_instr_rvalid = instr_rvalid_o; cap_data_rvalid = data_rvalid_o; cap_xif_rvalid = xif_rvalid_o;
    cap_instr_rdata = instr_rdata_o; cap_xif_rdata = xif_rdata_o;
    cap_mem_addr = mem_addr_o; cap_mem_we = mem_we_o; cap_mem_be = mem_be_o; cap_mem_wdata = mem_wdata_o;
  endtask

  // Reference model: predicts this cycle's outputs from the rules and checks the DUT.
  task automatic predict_and_check();
    bit               any;
    logic [31:0]      e_addr;
    logic             e_we;
    logic [BE_W-1:0]  e_be;
    logic [MEM_W-1:0] e_wd;
    logic [MEM_W-1:0] rd;
    int               hs, hl;
    any = instr_req_i | data_req_i | xif_req_i;
    p_req = any && (m_q.size() < DEPTH);
    if (!any) p_sel = SEL_NONE;
    else if (instr_req_i && m_starve >= STARVE_MAX) p_sel = SEL_I;
    else if (data_req_i && xif_req_i) p_sel = m_last_xif ? SEL_D : SEL_X;
    else if (data_req_i) p_sel = SEL_D;
    else if (xif_req_i) p_sel = SEL_X;
    else p_sel = SEL_I;
    p_acc = p_req && mem_gnt_i;
    p_pop = mem_rvalid_i && (m_q.size() > 0);
    check_output("mem_req", mem_req_o, p_req);
    check_output("instr_gnt", instr_gnt_o, p_acc && p_sel == SEL_I);
    check_output("data_gnt", data_gnt_o, p_acc && p_sel == SEL_D);
    check_output("xif_gnt", xif_gnt_o, p_acc && p_sel == SEL_X);
    check_output("busy", busy_o, m_q.size() != 0);
    check_output("proto_err", proto_err_o, m_proto);
    if (p_req) begin
      e_wd = '0;
      if (p_sel == SEL_I) begin
        e_addr = instr_addr_i; e_we = 1'b0; e_be = '1;
      end else if (p_sel == SEL_D) begin
        e_addr = data_addr_i; e_we = data_we_i; e_be = data_be_i; e_wd = data_wdata_i;
      end else begin
        e_addr = xif_addr_i; e_we = xif_we_i; e_be = '0;
        for (int b = 0; b < 4; b++) e_be[4 * lane_of(xif_addr_i) + b] = 1'b1;
        for (int l = 0; l < LANES; l++) e_wd[32 * l +: 32] = xif_wdata_i;
      end
      check_output("mem_addr", mem_addr_o, e_addr);
      check_output("mem_we", mem_we_o, e_we);
      check_output("mem_be", mem_be_o, e_be);
      if (p_sel != SEL_I) check_output("mem_wdata", mem_wdata_o, e_wd);
    end
    hs = SEL_NONE;
    hl = 0;
    if (p_pop) begin
      hs = m_q[0].src;
      hl = m_q[0].lane;
    end
    check_output("instr_rvalid", instr_rvalid_o, hs == SEL_I);
    check_output("data_rvalid", data_rvalid_o, hs == SEL_D);
    check_output("xif_rvalid", xif_rvalid_o, hs == SEL_X);
    rd = mem_rdata_i;
    if (hs == SEL_I) begin
      check_output("instr_rdata", instr_rdata_o, rd[hl * 32 +: 32]);
      check_output("instr_err", instr_err_o, mem_err_i);
    end
    if (hs == SEL_D) begin
      check_output("data_rdata", data_rdata_o, rd);
      check_output("data_err", data_err_o, mem_err_i);
    end
    if (hs == SEL_X) begin
      check_output("xif_rdata", xif_rdata_o, rd[hl * 32 +: 32]);
      check_output("xif_err", xif_err_o, mem_err_i);
    end
  endtask

  task automatic model_update();
    tag_t t;
    if (p_pop) t = m_q.pop_front();
    if (p_acc) begin
      t.src = p_sel;
      if (p_sel == SEL_I) t.lane = lane_of(instr_addr_i);
      else if (p_sel == SEL_D) t.lane = lane_of(data_addr_i);
      else t.lane = lane_of(xif_addr_i);
      m_q.push_back(t);
    end
    if (instr_req_i && !(p_acc && p_sel == SEL_I)) begin
      if (m_starve < STARVE_MAX) m_starve++;
    end else begin
      m_starve = 0;
    end
    if (p_acc && p_sel == SEL_D) m_last_xif = 1'b0;
    if (p_acc && p_sel == SEL_X) m_last_xif = 1'b1;
    if (mem_rvalid_i && !p_pop) m_proto = 1'b1;
  endtask

  task automatic step();
    @(negedge clk_i);
    capture();
    predict_and_check();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("rst_mem_req", mem_req_o, 1'b0);
    check_output("rst_gnts", {instr_gnt_o, data_gnt_o, xif_gnt_o}, 3'b000);
    check_output("rst_rvalids", {instr_rvalid_o, data_rvalid_o, xif_rvalid_o}, 3'b000);
    check_output("rst_busy", busy_o, 1'b0);
    check_output("rst_proto", proto_err_o, 1'b0);
    idle_inputs();
    m_q.delete();
    m_starve = 0;
    m_last_xif = 1'b1;
    m_proto = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus();
    instr_req_i  = 1'($urandom_range(0, 1));
    instr_addr_i = $urandom & 32'hFFFF_FFFC;
    data_req_i   = 1'($urandom_range(0, 1));
    data_addr_i  = $urandom & 32'hFFFF_FFFC;
    data_we_i    = 1'($urandom_range(0, 1));
    data_be_i    = BE_W'($urandom);
    data_wdata_i = {$urandom, $urandom};
    xif_req_i    = 1'($urandom_range(0, 1));
    xif_addr_i   = $urandom & 32'hFFFF_FFFC;
    xif_we_i     = 1'($urandom_range(0, 1));
    xif_wdata_i  = $urandom;
    mem_gnt_i    = ($urandom_range(0, 3) != 0);
    mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
    mem_rdata_i  = {$urandom, $urandom};
    mem_err_i    = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int g, e;
    logic [31:0] xif_exp [4];
    logic [31:0] xif_addrs [4];

    idle_inputs();
    #1;
    do_reset();

    // Mux and selection vectors from the idle state, memory never granting.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 8'h00, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 8'hFF, 64'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 8'h0F, 64'h1122334455667788, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 32'h204, 1'b1, 8'hF0, 64'hCAFEBABECAFEBABE, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 8'h0F, 64'hCAFEBABECAFEBABE, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 32'h100, 1'b1, 8'h0F, 64'h1122334455667788, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h20C, 1'b1, 32'h20C, 1'b1, 8'hF0, 64'hCAFEBABECAFEBABE, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 32'h100, 1'b1, 8'h0F, 64'h1122334455667788, 1'b1};
    for (int i = 0; i < 8; i++) begin
      instr_req_i = vecs[i].ir; instr_addr_i = 32'h80;
      data_req_i = vecs[i].dr; data_addr_i = 32'h100; data_we_i = 1'b1;
      data_be_i = 8'h0F; data_wdata_i = 64'h1122334455667788;
      xif_req_i = vecs[i].xr; xif_addr_i = vecs[i].xa; xif_we_i = 1'b1; xif_wdata_i = 32'hCAFEBABE;
      step();
      check_output($sformatf("vec%0d_req", i), cap_mem_req, vecs[i].e_req);
      if (vecs[i].e_req) begin
        check_output($sformatf("vec%0d_addr", i), cap_mem_addr, vecs[i].e_addr);
        check_output($sformatf("vec%0d_we", i), cap_mem_we, vecs[i].e_we);
        check_output($sformatf("vec%0d_be", i), cap_mem_be, vecs[i].e_be);
        if (vecs[i].chk_wd) check_output($sformatf("vec%0d_wd", i), cap_mem_wdata, vecs[i].e_wd);
      end
    end
    do_reset();

    // Single fetch: grant in the request cycle, response one cycle later.
    instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
    step();
    check_output("fetch_gnt", cap_instr_gnt, 1'b1);
    check_output("fetch_busy0", cap_busy, 1'b0);
    instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_1234_5678;
    step();
    check_output("fetch_rvalid", cap_instr_rvalid, 1'b1);
    check_output("fetch_rdata", cap_instr_rdata, 32'h1234_5678);
    check_output("fetch_busy1", cap_busy, 1'b1);
    mem_rvalid_i = 1'b0;
    step();
    check_output("fetch_busy2", cap_busy, 1'b0);
    do_reset();

    // Continuous data/xif/instr pressure: alternation, then forced fetch on cycle 16.
    instr_req_i = 1'b1; data_req_i = 1'b1; xif_req_i = 1'b1; mem_gnt_i = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      mem_rvalid_i = (m_q.size() > 0);
      mem_rdata_i  = {$urandom, $urandom};
      step();
      g = cap_instr_gnt ? SEL_I : cap_data_gnt ? SEL_D : cap_xif_gnt ? SEL_X : SEL_NONE;
      if (cyc == 16) e = SEL_I;
      else if (cyc == 17) e = SEL_X;
      else if (cyc == 18) e = SEL_D;
      else e = (cyc % 2 == 1) ? SEL_D : SEL_X;
      check_output($sformatf("rr_cycle%0d", cyc), g, e);
    end
    do_reset();

    // Fill to DEPTH with xif reads, then drain and check lane routing.
    xif_addrs = '{32'h4, 32'h0, 32'hC, 32'h8};
    xif_exp   = '{32'hBBBB_0000, 32'hAAAA_0001, 32'hBBBB_0002, 32'hAAAA_0003};
    xif_req_i = 1'b1; xif_we_i = 1'b0; mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xif_addr_i = xif_addrs[i];
      step();
      check_output($sformatf("fill_gnt%0d", i), cap_xif_gnt, 1'b1);
    end
    step();
    check_output("full_mem_req", cap_mem_req, 1'b0);
    check_output("full_xif_gnt", cap_xif_gnt, 1'b0);
    xif_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = {32'hBBBB_0000 + 32'(i), 32'hAAAA_0000 + 32'(i)};
      step();
      check_output($sformatf("drain_rvalid%0d", i), cap_xif_rvalid, 1'b1);
      check_output($sformatf("drain_rdata%0d", i), cap_xif_rdata, xif_exp[i]);
    end
    mem_rvalid_i = 1'b0;
    step();
    check_output("drain_busy", cap_busy, 1'b0);
    do_reset();

    // Stray response with nothing outstanding: sticky protocol error until reset.
    mem_rvalid_i = 1'b1;
    step();
    check_output("stray_rvalids", {cap_instr_rvalid, cap_data_rvalid, cap_xif_rvalid}, 3'b000);
    mem_rvalid_i = 1'b0;
    repeat (3) begin
      step();
      check_output("stray_proto", cap_proto, 1'b1);
    end
    do_reset();

    // Reset with three outstanding transactions, then a stale response.
    data_req_i = 1'b1; data_addr_i = 32'h40; mem_gnt_i = 1'b1;
    repeat (3) step();
    mem_gnt_i = 1'b0;
    step();
    check_output("pre_reset_busy", cap_busy, 1'b1);
    do_reset();
    mem_rvalid_i = 1'b1;
    step();
    check_output("stale_rvalid", cap_data_rvalid, 1'b0);
    mem_rvalid_i = 1'b0;
    step();
    check_output("stale_proto", cap_proto, 1'b1);
    do_reset();

    // Randomized traffic with variable response delay against the model.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
